// File: rtl/call_panel_pkg.sv
// rtl/call_panel_pkg.sv - debounce state encoding and floor range shared with the elevator
// Optional re-issue feature: CALL_PANEL_REISSUE_EN (used by call_button and call_panel).
package call_panel_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,
        DB_ON  = 2'd1,
        HELD   = 2'd2,
        DB_OFF = 2'd3
    } db_state_t;

    localparam int FLOOR_MIN_DEF = 1;
    localparam int FLOOR_MAX_DEF = 8;
    localparam int PENDING_SAT   = 15;

endpackage

// File: rtl/call_button.sv
// rtl/call_button.sv - one call button: synchroniser, debounce FSM, lamp and request pulse
// Define CALL_PANEL_REISSUE_EN to re-pulse the request every RETRY_CYCLES while the lamp is lit.
module call_button
    import call_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
`ifdef CALL_PANEL_REISSUE_EN
    parameter int RETRY_CYCLES    = 200,
`endif
    parameter bit ENABLE          = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_clear,
    output logic o_lamp,
    output logic o_req
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lamp;
    logic          r_req;
    logic          w_synced;
    logic          w_accept;

`ifdef CALL_PANEL_REISSUE_EN
    localparam int            RW         = (RETRY_CYCLES > 2) ? $clog2(RETRY_CYCLES) : 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_CYCLES - 1);
    logic [RW-1:0] r_retry;
`endif

    assign w_synced = r_sync[1];
    assign w_accept = (r_state == DB_ON) && w_synced && (r_cnt == CNT_LAST);
    assign o_lamp   = r_lamp;
    assign o_req    = r_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= REL;
            r_cnt   <= '0;
            r_lamp  <= 1'b0;
            r_req   <= 1'b0;
`ifdef CALL_PANEL_REISSUE_EN
            r_retry <= '0;
`endif
        end else begin
            // A disabled button is tied off ahead of the synchroniser so its FSM never leaves REL.
            r_sync <= {r_sync[0], i_btn & ENABLE};
            r_req  <= 1'b0;

            case (r_state)
                REL: begin
                    r_cnt <= '0;
                    if (w_synced) r_state <= DB_ON;
                end
                DB_ON: begin
                    if (!w_synced) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    r_cnt <= '0;
                    if (!w_synced) r_state <= DB_OFF;
                end
                DB_OFF: begin
                    if (w_synced) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= REL;
                    r_cnt   <= '0;
                end
            endcase

            // Service clear beats a same-cycle accept; an accept on a lit lamp is ignored.
            if (i_clear) begin
                r_lamp  <= 1'b0;
`ifdef CALL_PANEL_REISSUE_EN
                r_retry <= '0;
`endif
            end else if (w_accept && !r_lamp) begin
                r_lamp  <= 1'b1;
                r_req   <= 1'b1;
`ifdef CALL_PANEL_REISSUE_EN
                r_retry <= '0;
            end else if (r_lamp) begin
                if (r_retry == RETRY_LAST) begin
                    r_req   <= 1'b1;
                    r_retry <= '0;
                end else begin
                    r_retry <= r_retry + 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/call_panel.sv
// rtl/call_panel.sv - elevator call panel: 3*FLOOR_MAX call buttons, floor service clear, lamp count
// Define CALL_PANEL_REISSUE_EN to enable periodic request re-issue while a lamp is lit.
module call_panel
    import call_panel_pkg::*;
#(
    parameter int FLOOR_MIN       = FLOOR_MIN_DEF,
    parameter int FLOOR_MAX       = FLOOR_MAX_DEF,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RETRY_CYCLES    = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLOOR_MAX-1:0] btn_cab,
    input  logic [FLOOR_MAX-1:0] btn_up,
    input  logic [FLOOR_MAX-1:0] btn_down,
    input  logic [3:0]           current_floor,
    input  logic                 door_state,
    output logic [FLOOR_MAX-1:0] internal_req,
    output logic [FLOOR_MAX-1:0] external_up_req,
    output logic [FLOOR_MAX-1:0] external_down_req,
    output logic [FLOOR_MAX-1:0] cab_lamp,
    output logic [FLOOR_MAX-1:0] up_lamp,
    output logic [FLOOR_MAX-1:0] down_lamp,
    output logic [3:0]           pending_cnt
);

    localparam int LIT_W = ($clog2(3 * FLOOR_MAX + 1) > 4) ? $clog2(3 * FLOOR_MAX + 1) : 5;

    logic [FLOOR_MAX-1:0] w_clear;
    logic [LIT_W-1:0]     w_lit;
    logic [3:0]           r_pending;

`ifndef CALL_PANEL_REISSUE_EN
    // Without re-issue the retry interval has no effect on the hardware.
    if (RETRY_CYCLES < 2) begin : g_retry_unused
    end
`endif

    for (genvar i = 0; i < FLOOR_MAX; i++) begin : g_floor
        localparam int FLOOR = i + 1;

        assign w_clear[i] = door_state && (FLOOR >= FLOOR_MIN) && (current_floor == 4'(FLOOR));

        call_button #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef CALL_PANEL_REISSUE_EN
            .RETRY_CYCLES   (RETRY_CYCLES),
`endif
            .ENABLE         (1'b1)
        ) u_cab (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btn_cab[i]),
            .i_clear(w_clear[i]),
            .o_lamp (cab_lamp[i]),
            .o_req  (internal_req[i])
        );

        // Top floor has no up call and bottom floor has no down call.
        call_button #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef CALL_PANEL_REISSUE_EN
            .RETRY_CYCLES   (RETRY_CYCLES),
`endif
            .ENABLE         (1'(i != FLOOR_MAX - 1))
        ) u_up (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btn_up[i]),
            .i_clear(w_clear[i]),
            .o_lamp (up_lamp[i]),
            .o_req  (external_up_req[i])
        );

        call_button #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef CALL_PANEL_REISSUE_EN
            .RETRY_CYCLES   (RETRY_CYCLES),
`endif
            .ENABLE         (1'(i != FLOOR_MIN - 1))
        ) u_down (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (btn_down[i]),
            .i_clear(w_clear[i]),
            .o_lamp (down_lamp[i]),
            .o_req  (external_down_req[i])
        );
    end

    always_comb begin
        w_lit = '0;
        for (int i = 0; i < FLOOR_MAX; i++) begin
            w_lit = w_lit + LIT_W'(cab_lamp[i]) + LIT_W'(up_lamp[i]) + LIT_W'(down_lamp[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else if (w_lit > LIT_W'(PENDING_SAT)) begin
            r_pending <= 4'(PENDING_SAT);
        end else begin
            r_pending <= w_lit[3:0];
        end
    end

    assign pending_cnt = r_pending;

endmodule

// File: tb/tb_call_panel.sv
// tb/tb_call_panel.sv - self-checking bench for call_panel against a run-length behavioural model
// Honours CALL_PANEL_REISSUE_EN when the design is built with re-issue enabled.
module tb_call_panel;

    localparam int FMAX = 8;
    localparam int DB   = 4;
    localparam int RT   = 20;
    localparam int NB   = 3 * FMAX;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [FMAX-1:0] btn_cab = '0, btn_up = '0, btn_down = '0;
    logic [3:0]      current_floor = '0;
    logic            door_state = 1'b0;
    logic [FMAX-1:0] internal_req, external_up_req, external_down_req;
    logic [FMAX-1:0] cab_lamp, up_lamp, down_lamp;
    logic [3:0]      pending_cnt;

    always #5 clk = ~clk;

    call_panel #(
        .FLOOR_MIN      (1),
        .FLOOR_MAX      (FMAX),
        .DEBOUNCE_CYCLES(DB),
        .RETRY_CYCLES   (RT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_cab          (btn_cab),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .current_floor    (current_floor),
        .door_state       (door_state),
        .internal_req     (internal_req),
        .external_up_req  (external_up_req),
        .external_down_req(external_down_req),
        .cab_lamp         (cab_lamp),
        .up_lamp          (up_lamp),
        .down_lamp        (down_lamp),
        .pending_cnt      (pending_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a button is "pressed" once its synchronised level has
    // disagreed with the debounced level for DB+1 samples in a row.
    int m_run[NB], m_held[NB], m_d1[NB], m_d2[NB], m_lamp[NB], m_pulse[NB], m_since[NB];
    int m_pend, m_lit;

    function automatic logic raw_bit(input int b);
        case (b / FMAX)
            0:       return btn_cab[b % FMAX];
            1:       return btn_up[b % FMAX];
            default: return btn_down[b % FMAX];
        endcase
    endfunction

    task automatic model_step(input int b);
        int kind, fl, samp;
        bit acc, clr, en;
        kind = b / FMAX;
        fl   = b % FMAX + 1;
        samp = m_d2[b];
        m_d2[b] = m_d1[b];
        m_d1[b] = int'(raw_bit(b));
        acc = 1'b0;
        if (samp != m_held[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == DB + 1) begin
            m_held[b] = 1 - m_held[b];
            m_run[b]  = 0;
            acc = (m_held[b] == 1);
        end
        clr = door_state && (int'(current_floor) == fl);
        en  = !((kind == 1 && fl == FMAX) || (kind == 2 && fl == 1));
        m_pulse[b] = 0;
        if (clr) begin
            m_lamp[b]  = 0;
            m_since[b] = 0;
        end else if (acc && en && m_lamp[b] == 0) begin
            m_lamp[b]  = 1;
            m_pulse[b] = 1;
            m_since[b] = 0;
        end
`ifdef CALL_PANEL_REISSUE_EN
        else if (m_lamp[b] == 1) begin
            m_since[b]++;
            if (m_since[b] == RT) begin
                m_pulse[b] = 1;
                m_since[b] = 0;
            end
        end
`endif
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            m_run[b] = 0; m_held[b] = 0; m_d1[b] = 0; m_d2[b] = 0;
            m_lamp[b] = 0; m_pulse[b] = 0; m_since[b] = 0;
        end
        m_pend = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                m_run[b] = 0; m_held[b] = 0; m_d1[b] = 0; m_d2[b] = 0;
                m_lamp[b] = 0; m_pulse[b] = 0; m_since[b] = 0;
            end
            m_pend = 0;
        end else begin
            m_lit = 0;
            for (int b = 0; b < NB; b++) m_lit += m_lamp[b];
            m_pend = (m_lit > 15) ? 15 : m_lit;
            for (int b = 0; b < NB; b++) model_step(b);
        end
    end

    logic [FMAX-1:0] e_ireq, e_ureq, e_dreq, e_cl, e_ul, e_dl;

    always @(negedge clk) begin
        for (int i = 0; i < FMAX; i++) begin
            e_ireq[i] = m_pulse[i][0];
            e_ureq[i] = m_pulse[FMAX + i][0];
            e_dreq[i] = m_pulse[2 * FMAX + i][0];
            e_cl[i]   = m_lamp[i][0];
            e_ul[i]   = m_lamp[FMAX + i][0];
            e_dl[i]   = m_lamp[2 * FMAX + i][0];
        end
        chk("internal_req", internal_req, e_ireq);
        chk("external_up_req", external_up_req, e_ureq);
        chk("external_down_req", external_down_req, e_dreq);
        chk("cab_lamp", cab_lamp, e_cl);
        chk("up_lamp", up_lamp, e_ul);
        chk("down_lamp", down_lamp, e_dl);
        chk("pending_cnt", pending_cnt, m_pend);
    end

    int pc[NB];

    always @(negedge clk) begin
        for (int i = 0; i < FMAX; i++) begin
            pc[i]            += int'(internal_req[i]);
            pc[FMAX + i]     += int'(external_up_req[i]);
            pc[2 * FMAX + i] += int'(external_down_req[i]);
        end
    end

    task automatic zero_pc();
        for (int b = 0; b < NB; b++) pc[b] = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        zero_pc();
        tick(3);
        chk("reset_internal_req", internal_req, 0);
        chk("reset_lamps", {cab_lamp, up_lamp, down_lamp}, 0);
        chk("reset_pending", pending_cnt, 0);

        // Cab floor 3 rises before edge 1 and is held.
        btn_cab[2] = 1'b1;
        rst = 1'b0;
        tick(6);
        chk("cab3_before_e7_req", internal_req, 0);
        chk("cab3_before_e7_lamp", cab_lamp, 0);
        tick(1);
        chk("cab3_e7_req", internal_req, 8'h04);
        chk("cab3_e7_lamp", cab_lamp, 8'h04);
        chk("model_pin_pulse", m_pulse[2], 1);
        tick(1);
        chk("cab3_e8_req", internal_req, 0);
        chk("cab3_e8_pending", pending_cnt, 1);
        chk("model_pin_pend", m_pend, 1);
        zero_pc();
        tick(10);
        chk("cab3_single_pulse", pc[2], 0);
        btn_cab[2] = 1'b0;
        tick(8);

        // Short glitch is rejected, a long press gives one pulse.
        zero_pc();
        btn_up[0] = 1'b1;
        tick(3);
        btn_up[0] = 1'b0;
        tick(12);
        chk("glitch_lamp", up_lamp[0], 0);
        chk("glitch_pulse", pc[FMAX], 0);
        btn_up[0] = 1'b1;
        tick(10);
        btn_up[0] = 1'b0;
        tick(10);
        chk("press_pulses", pc[FMAX], 1);
        chk("press_lamp", up_lamp[0], 1);

        // Service clear at floor 4.
        btn_up[3] = 1'b1;
        tick(10);
        btn_up[3] = 1'b0;
        tick(8);
        chk("up4_lamp", up_lamp[3], 1);
        chk("pending_three", pending_cnt, 3);
        current_floor = 4'd4;
        door_state = 1'b1;
        tick(1);
        chk("clear4_lamps", {cab_lamp[3], up_lamp[3], down_lamp[3]}, 0);
        door_state = 1'b0;
        tick(1);
        chk("clear4_pending", pending_cnt, 2);

        // Clear wins at floor 5; floor 6 accepted normally.
        zero_pc();
        current_floor = 4'd5;
        door_state = 1'b1;
        btn_cab[4] = 1'b1;
        btn_cab[5] = 1'b1;
        tick(12);
        chk("clear5_lamp", cab_lamp[4], 0);
        chk("clear5_pulse", pc[4], 0);
        chk("floor6_lamp", cab_lamp[5], 1);
        chk("floor6_pulse", pc[5], 1);
        btn_cab[4] = 1'b0;
        btn_cab[5] = 1'b0;
        door_state = 1'b0;
        current_floor = 4'd0;
        tick(8);

        // Non-existent hall buttons.
        zero_pc();
        btn_up[FMAX-1] = 1'b1;
        btn_down[0] = 1'b1;
        tick(12);
        chk("top_up_dead", {up_lamp[FMAX-1], pc[2*FMAX-1][0]}, 0);
        chk("bottom_down_dead", {down_lamp[0], pc[2*FMAX][0]}, 0);
        btn_up[FMAX-1] = 1'b0;
        btn_down[0] = 1'b0;
        tick(8);

        // Reset at debounce count 2 drops the event.
        btn_down[4] = 1'b1;
        tick(5);
        rst = 1'b1;
        #1;
        chk("rst_async_lamps", {cab_lamp, up_lamp, down_lamp}, 0);
        chk("rst_async_pending", pending_cnt, 0);
        chk("rst_async_req", {internal_req, external_up_req, external_down_req}, 0);
        btn_down[4] = 1'b0;
        tick(2);
        rst = 1'b0;
        zero_pc();
        tick(15);
        chk("rst_drop_pulse", pc[2*FMAX+4], 0);

        // Button held through reset release is debounced afresh.
        rst = 1'b1;
        btn_down[4] = 1'b1;
        tick(3);
        rst = 1'b0;
        zero_pc();
        tick(6);
        chk("held_rst_early", pc[2*FMAX+4], 0);
        tick(1);
        chk("held_rst_pulse", external_down_req[4], 1);
        chk("held_rst_lamp", down_lamp[4], 1);
        tick(1);
        chk("held_rst_pulse_end", external_down_req[4], 0);
`ifdef CALL_PANEL_REISSUE_EN
        zero_pc();
        tick(20);
        chk("reissue_pulse", pc[2*FMAX+4], 1);
        current_floor = 4'd5;
        door_state = 1'b1;
        tick(1);
        door_state = 1'b0;
        current_floor = 4'd0;
        zero_pc();
        tick(45);
        chk("reissue_after_clear", pc[2*FMAX+4], 0);
`endif
        btn_down[4] = 1'b0;
        tick(10);

        // Randomised traffic, clears and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < FMAX; i++) begin
                if ($urandom_range(0, 11) == 0) btn_cab[i]  = ~btn_cab[i];
                if ($urandom_range(0, 11) == 0) btn_up[i]   = ~btn_up[i];
                if ($urandom_range(0, 11) == 0) btn_down[i] = ~btn_down[i];
            end
            if ($urandom_range(0, 7) == 0) current_floor = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) door_state = ~door_state;
            if (!rst && $urandom_range(0, 799) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
